tmds_encoder_3ch: RTL

- Three-channel DVI 1.0 TMDS 8b/10b encoder in the clk_pixel domain.
- Sits directly downstream of the video timing and pattern generator.
- Consumes its vs/hs/de/r/g/b and produces three 10-bit symbols for the 10:1 serializers.
- Replaces the encoder inside the vendor DVI TX so the datapath is owned, visible and testable.

---
 rtl/tmds_encoder_3ch_pkg.sv | 24 ++
 rtl/tmds_encoder_3ch_if.sv | 30 +++
 rtl/tmds_encoder_3ch_channel_enc.sv | 95 +++++++++
 rtl/tmds_encoder_3ch.sv | 62 ++++++
 4 files changed

// File: rtl/tmds_encoder_3ch_pkg.sv
// tmds_pkg: shared constants and helpers for the three-channel TMDS encoder.
//   TMDS_CTL00..11 : control tokens sent during blanking, indexed by {C1,C0}
//   SYM_W / DISP_W : symbol width and running-disparity width
//   popcount8      : number of ones in a byte (0..8)
package tmds_pkg;

    localparam int SYM_W  = 10;
    localparam int DISP_W = 5;

    localparam logic [SYM_W-1:0] TMDS_CTL00 = 10'h354;
    localparam logic [SYM_W-1:0] TMDS_CTL01 = 10'h0AB;
    localparam logic [SYM_W-1:0] TMDS_CTL10 = 10'h154;
    localparam logic [SYM_W-1:0] TMDS_CTL11 = 10'h2AB;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_encoder_3ch_if.sv
// tmds_encoder_3ch_if: pixel bus in, TMDS symbols out.
//   rgb_vs/rgb_hs/rgb_de/rgb_r/rgb_g/rgb_b : from the video timing generator
//   tmds_ch0/1/2 : 10-bit symbols (blue/green/red), bit 0 transmitted first
//   de_out       : rgb_de aligned with the symbols
//   master = pixel source side, slave = encoder side
interface tmds_encoder_3ch_if;
    import tmds_pkg::*;

    logic             rgb_vs;
    logic             rgb_hs;
    logic             rgb_de;
    logic [7:0]       rgb_r;
    logic [7:0]       rgb_g;
    logic [7:0]       rgb_b;
    logic [SYM_W-1:0] tmds_ch0;
    logic [SYM_W-1:0] tmds_ch1;
    logic [SYM_W-1:0] tmds_ch2;
    logic             de_out;

    modport master (
        output rgb_vs, rgb_hs, rgb_de, rgb_r, rgb_g, rgb_b,
        input  tmds_ch0, tmds_ch1, tmds_ch2, de_out
    );

    modport slave (
        input  rgb_vs, rgb_hs, rgb_de, rgb_r, rgb_g, rgb_b,
        output tmds_ch0, tmds_ch1, tmds_ch2, de_out
    );

endinterface

// File: rtl/tmds_encoder_3ch_channel_enc.sv
// tmds_channel_enc: one TMDS channel, two pipeline stages.
//   Stage 1: transition-minimising q_m[8:0], registered with de and C1:C0.
//   Stage 2: DC balancing against a running disparity, or control token.
// Ports:
//   clk_pixel, rst_n : pixel clock, async active-low reset
//   d_in, c_in, de_in: pixel byte, control bits {C1,C0}, data enable
//   sym_out          : registered 10-bit symbol
module tmds_channel_enc
    import tmds_pkg::*;
(
    input  logic             clk_pixel,
    input  logic             rst_n,
    input  logic [7:0]       d_in,
    input  logic [1:0]       c_in,
    input  logic             de_in,
    output logic [SYM_W-1:0] sym_out
);

    logic [8:0]              qm_d, qm_q;
    logic                    de_d, de_q;
    logic [1:0]              c_d, c_q;
    logic [SYM_W-1:0]        sym_d, sym_q;
    logic signed [DISP_W-1:0] cnt_d, cnt_q;

    logic [3:0]              n1_in;
    logic                    use_xnor;
    logic [7:0]              chain;
    logic [3:0]              n1_q, n0_q;
    logic signed [DISP_W-1:0] disp;
    logic signed [DISP_W-1:0] two_q8;
    logic signed [DISP_W-1:0] two_nq8;

    always_comb begin
        n1_in    = popcount8(d_in);
        use_xnor = (n1_in > 4'd4) || ((n1_in == 4'd4) && !d_in[0]);
        chain    = 8'h00;
        chain[0] = d_in[0];
        for (int i = 1; i < 8; i++) begin
            chain[i] = use_xnor ? ~(chain[i-1] ^ d_in[i]) : (chain[i-1] ^ d_in[i]);
        end
        qm_d = {~use_xnor, chain};
        de_d = de_in;
        c_d  = c_in;
    end

    always_comb begin
        n1_q    = popcount8(qm_q[7:0]);
        n0_q    = 4'd8 - n1_q;
        // n1-n0, both zero-extended so the subtraction is signed 5-bit
        disp    = $signed({1'b0, n1_q}) - $signed({1'b0, n0_q});
        two_q8  = $signed({3'b000, qm_q[8], 1'b0});
        two_nq8 = $signed({3'b000, ~qm_q[8], 1'b0});
        sym_d   = TMDS_CTL00;
        cnt_d   = cnt_q;
        if (!de_q) begin
            case (c_q)
                2'b00:   sym_d = TMDS_CTL00;
                2'b01:   sym_d = TMDS_CTL01;
                2'b10:   sym_d = TMDS_CTL10;
                default: sym_d = TMDS_CTL11;
            endcase
            cnt_d = '0;
        end else if ((cnt_q == '0) || (n1_q == n0_q)) begin
            sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d = qm_q[8] ? (cnt_q + disp) : (cnt_q - disp);
        end else if ((!cnt_q[DISP_W-1] && (n1_q > n0_q)) ||
                     (cnt_q[DISP_W-1] && (n0_q > n1_q))) begin
            // cnt_q is nonzero here, so a clear sign bit means positive
            sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d = cnt_q + two_q8 - disp;
        end else begin
            sym_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d = cnt_q - two_nq8 + disp;
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            qm_q  <= '0;
            de_q  <= 1'b0;
            c_q   <= 2'b00;
            sym_q <= TMDS_CTL00;
            cnt_q <= '0;
        end else begin
            qm_q  <= qm_d;
            de_q  <= de_d;
            c_q   <= c_d;
            sym_q <= sym_d;
            cnt_q <= cnt_d;
        end
    end

    assign sym_out = sym_q;

endmodule

// File: rtl/tmds_encoder_3ch.sv
// tmds_encoder_3ch: DVI TMDS encoder for blue/green/red, two-cycle latency.
// Ports:
//   clk_pixel, rst_n : pixel clock, async active-low reset
//   bus (slave)      : pixel inputs in, tmds_ch0/1/2 and de_out out
// Parameters:
//   CTRL_CH1 / CTRL_CH2 : {C1,C0} sent on green / red during blanking
//   Blue carries {vs, hs} unmodified.
module tmds_encoder_3ch
    import tmds_pkg::*;
#(
    parameter logic [1:0] CTRL_CH1 = 2'b00,
    parameter logic [1:0] CTRL_CH2 = 2'b00
) (
    input  logic                clk_pixel,
    input  logic                rst_n,
    tmds_encoder_3ch_if.slave   bus
);

    logic [1:0] de_pipe_d, de_pipe_q;

    tmds_channel_enc u_ch0 (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .d_in      (bus.rgb_b),
        .c_in      ({bus.rgb_vs, bus.rgb_hs}),
        .de_in     (bus.rgb_de),
        .sym_out   (bus.tmds_ch0)
    );

    tmds_channel_enc u_ch1 (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .d_in      (bus.rgb_g),
        .c_in      (CTRL_CH1),
        .de_in     (bus.rgb_de),
        .sym_out   (bus.tmds_ch1)
    );

    tmds_channel_enc u_ch2 (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .d_in      (bus.rgb_r),
        .c_in      (CTRL_CH2),
        .de_in     (bus.rgb_de),
        .sym_out   (bus.tmds_ch2)
    );

    always_comb begin
        de_pipe_d = {de_pipe_q[0], bus.rgb_de};
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            de_pipe_q <= 2'b00;
        end else begin
            de_pipe_q <= de_pipe_d;
        end
    end

    assign bus.de_out = de_pipe_q[1];

endmodule
